// File: rtl/fp_quad_sum_sequencer.sv
// fp_quad_sum_sequencer
// Sequential front end for the combinational 4-operand float adder.
// The block collects stream words into groups of four and holds each group
// stable on the adder operand ports for one cycle. It then registers the
// adder result and hands it downstream over a valid/ready handshake.
//
// Ports:
//   clk, reset             rising-edge clock, synchronous active-high reset
//   in_valid/in_ready      upstream word handshake (in_ready depends on state only)
//   in_data, in_last       operand word; in_last closes a partial group
//   op_a..op_d             registered operands driven to adder a..d
//   sum_hexres             adder result, combinational from op_a..op_d
//   out_valid/out_ready    result handshake (out_valid is registered)
//   out_data               captured sum_hexres
//   out_count              number of real operands in the group (1..4)
//   out_last               group was closed by in_last
module fp_quad_sum_sequencer #(
  parameter logic [31:0] PAD_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic [31:0] op_c,
  output logic [31:0] op_d,
  input  logic [31:0] sum_hexres,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [2:0]  out_count,
  output logic        out_last
);

  typedef enum logic [1:0] {FILL, LAUNCH, HOLD} state_t;

  state_t            state, state_nxt;
  logic [3:0][31:0]  slot;   // slot[0] feeds op_a ... slot[3] feeds op_d
  logic [1:0]        idx;
  logic [2:0]        count;
  logic              last;
  logic              accept;
  logic              close_grp;

  // in_ready is a pure function of state, so there is no in_valid->in_ready path
  assign in_ready  = (state == FILL);
  assign accept    = in_valid && in_ready;
  // slot 3 always launches, so idx never has to wrap inside a group
  assign close_grp = accept && ((idx == 2'd3) || in_last);

  assign op_a = slot[0];
  assign op_b = slot[1];
  assign op_c = slot[2];
  assign op_d = slot[3];

  always_ff @(posedge clk) begin
    if (reset) state <= FILL;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FILL:    if (close_grp) state_nxt = LAUNCH;
      LAUNCH:  state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot      <= {4{PAD_WORD}};
      idx       <= 2'd0;
      count     <= 3'd0;
      last      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 32'd0;
      out_count <= 3'd0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (accept) begin
            slot[idx] <= in_data;
            idx       <= idx + 2'd1;
          end
          if (close_grp) begin
            count <= {1'b0, idx} + 3'd1;
            last  <= in_last;
          end
        end
        LAUNCH: begin
          // operands have been stable since the closing accept edge
          out_data  <= sum_hexres;
          out_count <= count;
          out_last  <= last;
          out_valid <= 1'b1;
        end
        HOLD: begin
          // out_data/count/last stay as captured; only the operands are cleared
          if (out_ready) begin
            out_valid <= 1'b0;
            slot      <= {4{PAD_WORD}};
            idx       <= 2'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_quad_sum_sequencer.sv
module tb_fp_quad_sum_sequencer;
  localparam logic [31:0] PAD = 32'h0080_0000;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, in_last, out_valid, out_ready, out_last;
  logic [31:0] in_data, op_a, op_b, op_c, op_d, sum_hexres, out_data;
  logic [2:0]  out_count;
  logic        force_en;
  logic [31:0] force_val;
  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fp_quad_sum_sequencer #(.PAD_WORD(PAD)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .op_a(op_a), .op_b(op_b),
    .op_c(op_c), .op_d(op_d), .sum_hexres(sum_hexres), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_count(out_count),
    .out_last(out_last)
  );

  // Stand-in for the adder: any operand-sensitive function will do
  function automatic logic [31:0] adder_model(input logic [3:0][31:0] o);
    return (o[0] + {o[1][15:0], o[1][31:16]}) ^ (o[2] * 32'd3) ^ ~o[3];
  endfunction

  assign sum_hexres = force_en ? force_val
                               : adder_model({op_d, op_c, op_b, op_a});

  typedef struct {
    logic [3:0][31:0] ops;
    logic [31:0]      data;
    logic [2:0]       cnt;
    logic             lst;
  } grp_t;

  typedef struct {
    logic [3:0][31:0] ops;
    logic [31:0]      data;
    logic [2:0]       cnt;
    logic             lst;
    int               lat;
    int               bp_bad;
    logic             vld_after;
    logic             rdy_after;
    logic [3:0][31:0] ops_after;
  } obs_t;

  // Reference: a group is the words in stream order, padded to four
  function automatic grp_t model_group(input logic [31:0] w[4], input int n,
                                       input logic lst, input logic fe,
                                       input logic [31:0] fv);
    grp_t g;
    g.ops = {4{PAD}};
    for (int i = 0; i < n; i++) g.ops[i] = w[i];
    g.cnt  = 3'(n);
    g.lst  = lst;
    g.data = fe ? fv : adder_model(g.ops);
    return g;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push_word(input logic [31:0] d, input logic l, input int gap,
                           output int acc);
    int t;
    for (int g = 0; g < gap; g++) begin
      in_valid = 1'b0; in_data = $urandom; in_last = 1'($urandom); step();
    end
    in_valid = 1'b1; in_data = d; in_last = l; t = 0;
    while (!in_ready && t < 50) begin step(); t++; end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL push_timeout in_ready=%b required=1", in_ready);
    end
    step();
    acc = cyc;
  endtask

  // Called right after the closing accept edge
  task automatic finish_group(input int stall, output obs_t o);
    int t;
    logic [3:0][31:0] op0;
    t = 0;
    o.bp_bad = 0;
    o.ops = {op_d, op_c, op_b, op_a};
    while (!out_valid && t < 20) begin step(); t++; end
    o.lat = t; o.data = out_data; o.cnt = out_count; o.lst = out_last;
    op0 = {op_d, op_c, op_b, op_a};
    for (int s = 0; s < stall; s++) begin
      in_valid = 1'b1; in_data = $urandom; in_last = 1'($urandom);
      if (in_ready !== 1'b0) o.bp_bad++;
      step();
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== o.data ||
          out_count !== o.cnt || out_last !== o.lst ||
          {op_d, op_c, op_b, op_a} !== op0) o.bp_bad++;
    end
    out_ready = 1'b1; step();
    out_ready = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    o.vld_after = out_valid; o.rdy_after = in_ready;
    o.ops_after = {op_d, op_c, op_b, op_a};
  endtask

  task automatic test_reset();
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_data !== 32'd0 ||
        out_count !== 3'd0 || out_last !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs got rdy=%b vld=%b data=%h cnt=%0d last=%b, want 1 0 0 0 0",
               in_ready, out_valid, out_data, out_count, out_last);
    end
    tests++;
    if ({op_d, op_c, op_b, op_a} !== {4{PAD}}) begin
      fails++;
      $display("FAIL reset_ops got %h %h %h %h want %h", op_a, op_b, op_c, op_d, PAD);
    end
  endtask

  task automatic test_full_group();
    logic [31:0] w[4];
    grp_t e; obs_t o; int acc;
    w[0] = 32'h11e1d230; w[1] = 32'h0c9dc560; w[2] = 32'h81fbe970; w[3] = 32'h01caf760;
    force_en = 1'b1; force_val = 32'hA5A5_0000;
    for (int i = 0; i < 4; i++) push_word(w[i], 1'b0, 0, acc);
    finish_group(0, o);
    e = model_group(w, 4, 1'b0, 1'b1, 32'hA5A5_0000);
    force_en = 1'b0;
    tests++;
    if (o.ops !== e.ops) begin fails++; $display("FAIL full_ops got %h want %h", o.ops, e.ops); end
    tests++;
    if (o.lat !== 1) begin fails++; $display("FAIL full_latency got %0d want 1", o.lat); end
    tests++;
    if (o.data !== e.data || o.cnt !== e.cnt || o.lst !== e.lst) begin
      fails++;
      $display("FAIL full_result got %h/%0d/%b want %h/%0d/%b", o.data, o.cnt, o.lst, e.data, e.cnt, e.lst);
    end
    tests++;
    if (o.vld_after !== 1'b0 || o.rdy_after !== 1'b1 || o.ops_after !== {4{PAD}}) begin
      fails++;
      $display("FAIL full_release got vld=%b rdy=%b ops=%h", o.vld_after, o.rdy_after, o.ops_after);
    end
  endtask

  task automatic test_partial();
    logic [31:0] w[4];
    grp_t e; obs_t o; int acc;
    w[0] = 32'h4201_51EC; w[1] = 32'h4242_147B; w[2] = 0; w[3] = 0;
    push_word(w[0], 1'b0, 0, acc);
    push_word(w[1], 1'b1, 0, acc);
    finish_group(0, o);
    e = model_group(w, 2, 1'b1, 1'b0, 32'd0);
    tests++;
    if (o.ops !== e.ops) begin fails++; $display("FAIL partial_ops got %h want %h", o.ops, e.ops); end
    tests++;
    if (o.data !== e.data || o.cnt !== 3'd2 || o.lst !== 1'b1 || o.lat !== 1) begin
      fails++;
      $display("FAIL partial_result got %h/%0d/%b lat %0d want %h/2/1 lat 1", o.data, o.cnt, o.lst, o.lat, e.data);
    end
    tests++;
    if (o.vld_after !== 1'b0 || o.rdy_after !== 1'b1 || o.ops_after !== {4{PAD}}) begin
      fails++;
      $display("FAIL partial_release got vld=%b rdy=%b ops=%h", o.vld_after, o.rdy_after, o.ops_after);
    end
  endtask

  task automatic test_back_pressure();
    logic [31:0] w[4];
    grp_t e; obs_t o; int acc;
    for (int i = 0; i < 4; i++) w[i] = $urandom;
    for (int i = 0; i < 4; i++) push_word(w[i], 1'b0, 0, acc);
    finish_group(10, o);
    e = model_group(w, 4, 1'b0, 1'b0, 32'd0);
    tests++;
    if (o.bp_bad !== 0) begin fails++; $display("FAIL bp_stable got %0d changes want 0", o.bp_bad); end
    tests++;
    if (o.data !== e.data || o.cnt !== 3'd4 || o.ops !== e.ops) begin
      fails++;
      $display("FAIL bp_result got %h/%0d want %h/4", o.data, o.cnt, e.data);
    end
    tests++;
    if (o.rdy_after !== 1'b1 || o.ops_after !== {4{PAD}}) begin
      fails++;
      $display("FAIL bp_release got rdy=%b ops=%h", o.rdy_after, o.ops_after);
    end
  endtask

  task automatic test_single();
    logic [31:0] w[4];
    grp_t e; obs_t o; int acc;
    w[0] = 32'h42A1_B333; w[1] = 0; w[2] = 0; w[3] = 0;
    push_word(w[0], 1'b1, 0, acc);
    finish_group(1, o);
    e = model_group(w, 1, 1'b1, 1'b0, 32'd0);
    tests++;
    if (o.ops !== e.ops || o.data !== e.data || o.cnt !== 3'd1 || o.lst !== 1'b1) begin
      fails++;
      $display("FAIL single got ops=%h %h/%0d/%b want ops=%h %h/1/1", o.ops, o.data, o.cnt, o.lst, e.ops, e.data);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w[4];
    grp_t e; obs_t o; int acc; int seen;
    for (int i = 0; i < 3; i++) push_word($urandom, 1'b0, 0, acc);
    in_valid = 1'b0; reset = 1'b1; step(); reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 3; i++) begin if (out_valid) seen++; step(); end
    tests++;
    if (seen !== 0 || in_ready !== 1'b1 || {op_d, op_c, op_b, op_a} !== {4{PAD}}) begin
      fails++;
      $display("FAIL reset_mid_abort got vld_cycles=%0d rdy=%b ops=%h %h %h %h", seen, in_ready, op_a, op_b, op_c, op_d);
    end
    for (int i = 0; i < 4; i++) w[i] = $urandom;
    for (int i = 0; i < 4; i++) push_word(w[i], 1'b0, 0, acc);
    finish_group(0, o);
    e = model_group(w, 4, 1'b0, 1'b0, 32'd0);
    tests++;
    if (o.ops !== e.ops || o.data !== e.data || o.cnt !== 3'd4) begin
      fails++;
      $display("FAIL reset_mid_new got %h/%0d want %h/4", o.data, o.cnt, e.data);
    end
  endtask

  task automatic test_gapped();
    logic [31:0] w[4];
    grp_t e; obs_t o; int acc;
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < 4; i++) w[i] = $urandom;
      for (int i = 0; i < 4; i++) push_word(w[i], 1'b0, 1, acc);
      finish_group(0, o);
      e = model_group(w, 4, 1'b0, 1'b0, 32'd0);
      tests++;
      if (o.ops !== e.ops || o.data !== e.data || o.cnt !== 3'd4 || o.lst !== 1'b0) begin
        fails++;
        $display("FAIL gapped_%0d got ops=%h %h/%0d want ops=%h %h/4", g, o.ops, o.data, o.cnt, e.ops, e.data);
      end
    end
  endtask

  task automatic test_back_to_back();
    obs_t o; int a0, a1, acc;
    push_word($urandom, 1'b0, 0, a0);
    for (int i = 0; i < 3; i++) push_word($urandom, 1'b0, 0, acc);
    finish_group(0, o);
    push_word($urandom, 1'b0, 0, a1);
    for (int i = 0; i < 3; i++) push_word($urandom, 1'b0, 0, acc);
    finish_group(0, o);
    tests++;
    if (a1 - a0 !== 6) begin fails++; $display("FAIL b2b_period got %0d want 6", a1 - a0); end
  endtask

  task automatic test_random();
    logic [31:0] w[4];
    grp_t e; obs_t o; int acc; int n; logic lst; int bad;
    bad = 0;
    for (int k = 0; k < 25; k++) begin
      n   = $urandom_range(1, 4);
      lst = (n < 4) ? 1'b1 : 1'($urandom);
      for (int i = 0; i < 4; i++) w[i] = $urandom;
      for (int i = 0; i < n; i++)
        push_word(w[i], (i == n - 1) ? lst : 1'b0, $urandom_range(0, 2), acc);
      finish_group($urandom_range(0, 3), o);
      e = model_group(w, n, lst, 1'b0, 32'd0);
      if (o.ops !== e.ops || o.data !== e.data || o.cnt !== e.cnt || o.lst !== e.lst ||
          o.lat !== 1 || o.bp_bad !== 0 || o.vld_after !== 1'b0 || o.ops_after !== {4{PAD}}) begin
        bad++;
        $display("FAIL random_%0d got %h/%0d/%b lat %0d want %h/%0d/%b lat 1",
                 k, o.data, o.cnt, o.lst, o.lat, e.data, e.cnt, e.lst);
      end
    end
    tests++;
    if (bad !== 0) begin fails++; $display("FAIL random_groups got %0d bad groups want 0", bad); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 32'd0; in_last = 1'b0;
    out_ready = 1'b0; force_en = 1'b0; force_val = 32'd0;
    step(); step();
    reset = 1'b0;
    test_reset();
    test_full_group();
    test_partial();
    test_back_pressure();
    test_single();
    test_reset_mid();
    test_gapped();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
